// File: rtl/buffer_pedidos_if.sv
// Keypad/control-unit side signals of the request buffer.
// master: keypad and control unit; slave: buffer_pedidos.
interface buffer_pedidos_if;
    logic [3:0] origem_in;
    logic [3:0] destino_in;
    logic       registra;
    logic       ocupado;
    logic       aceito;
    logic [3:0] origem;
    logic [3:0] destino;
    logic       novaEntrada;
    logic       vazio;
    logic       cheio;
    logic       erro_pedido;
    logic [3:0] num_pedidos;

    modport master (
        output origem_in, destino_in, registra, ocupado, aceito,
        input  origem, destino, novaEntrada, vazio, cheio,
        input  erro_pedido, num_pedidos
    );

    modport slave (
        input  origem_in, destino_in, registra, ocupado, aceito,
        output origem, destino, novaEntrada, vazio, cheio,
        output erro_pedido, num_pedidos
    );
endinterface

// File: rtl/buffer_pedidos.sv
// Elevator request buffer: validates keypad (origem, destino) pairs,
// queues them in a FIFO and presents the oldest one to the control unit.
module buffer_pedidos #(
    parameter int DEPTH     = 4,
    parameter int ANDAR_MAX = 15
) (
    input  logic              clock,
    input  logic              reset,
    buffer_pedidos_if.slave   bus
);
    localparam int         PW     = $clog2(DEPTH);
    localparam logic [3:0] LP_MAX = 4'(ANDAR_MAX);
    localparam logic [3:0] LP_DEP = 4'(DEPTH);

    typedef enum logic [1:0] {
        OCIOSO,
        APRESENTA,
        INTERVALO
    } estado_t;

    estado_t       r_estado;
    estado_t       w_prox;
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [3:0]    r_count;
    logic          r_registra_d;
    logic          r_erro;

    logic          w_press;
    logic          w_valido;
    logic          w_push;
    logic          w_pop;
    logic          w_vazio;
    logic [7:0]    w_head;

    assign w_press  = bus.registra & ~r_registra_d;
    // Full check deliberately uses the pre-pop count.
    assign w_valido = (bus.origem_in <= LP_MAX)
                    && (bus.destino_in <= LP_MAX)
                    && (bus.origem_in != bus.destino_in)
                    && (r_count < LP_DEP);
    assign w_push   = w_press & w_valido;
    assign w_pop    = bus.aceito & (r_estado == APRESENTA);
    assign w_vazio  = (r_count == 4'd0);
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= 4'd0;
            r_registra_d <= 1'b1;
            r_erro       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
        end else begin
            r_registra_d <= bus.registra;
            r_erro       <= w_press & ~w_valido;
            if (w_push) begin
                r_mem[r_wr_ptr] <= {bus.origem_in, bus.destino_in};
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    // INTERVALO forces two low cycles so the downstream edge detector re-arms.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO: begin
                if (!w_vazio && !bus.ocupado) begin
                    w_prox = APRESENTA;
                end
            end
            APRESENTA: begin
                if (bus.aceito) begin
                    w_prox = INTERVALO;
                end
            end
            INTERVALO: begin
                w_prox = OCIOSO;
            end
            default: begin
                w_prox = OCIOSO;
            end
        endcase
    end

    assign bus.origem      = w_vazio ? 4'd0 : w_head[7:4];
    assign bus.destino     = w_vazio ? 4'd0 : w_head[3:0];
    assign bus.novaEntrada = (r_estado == APRESENTA);
    assign bus.vazio       = w_vazio;
    assign bus.cheio       = (r_count == LP_DEP);
    assign bus.erro_pedido = r_erro;
    assign bus.num_pedidos = r_count;
endmodule

// File: doc/buffer_pedidos.md
Name: buffer_pedidos

Overview:
- Request-input stage directly upstream of the elevator datapath.
- Captures user (origem, destino) floor pairs from the keypad on a button press and validates them.
- Stores valid pairs in a small FIFO.
- Presents the oldest pair to the datapath/control unit on origem/destino, with novaEntrada as a level that the datapath's edge detector turns into a pulse.
- The control unit pops the pair with a one-cycle aceito.

Parameters:
DEPTH, 4, FIFO depth in request pairs (power of 2, 2..8).
ANDAR_MAX, 15, highest valid floor number (0..15).

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
origem_in  in  4  keypad origin floor.
destino_in  in  4  keypad destination floor.
registra  in  1  "register request" button, level, synchronous to clock.
ocupado  in  1  control unit busy; no new request is presented while high.
aceito  in  1  one-cycle pop strobe from the control unit (regs latched).
origem  out  4  head-of-FIFO origin floor.
destino  out  4  head-of-FIFO destination floor.
novaEntrada  out  1  request-available level to the datapath.
vazio  out  1  FIFO empty.
cheio  out  1  FIFO full (count == DEPTH).
erro_pedido  out  1  one-cycle pulse: request rejected.
num_pedidos  out  4  current FIFO occupancy, 0..DEPTH.

Behaviour:

Reset:
- Pointers = 0 and count = 0, so vazio=1, cheio=0, num_pedidos=0.
- FSM = OCIOSO, novaEntrada=0, erro_pedido=0.
- origem/destino = 0 (head reads 0 when empty).
- Internal registra_d = 1, so a button held through reset is not a press.
- Reset mid-operation discards all stored requests.

Press detection:
- press = registra & ~registra_d, evaluated each cycle.
- registra_d <= registra.

Validation on press, same cycle:
- Valid iff origem_in <= ANDAR_MAX, destino_in <= ANDAR_MAX, origem_in != destino_in, and count < DEPTH (the count before this cycle's pop).
- Valid: write the pair at wr_ptr, wr_ptr+1 (mod DEPTH), count+1.
- Invalid: nothing stored; erro_pedido=1 in the following cycle only.
- No duplicate filtering; identical pairs are stored twice.

Pop:
- Occurs when aceito=1 and FSM=APRESENTA: rd_ptr+1 (mod DEPTH), count-1.
- aceito in any other state is ignored, including when the FIFO is empty.

Simultaneous push and pop:
- Both take effect; count unchanged.
- When full, the push is rejected even if a pop occurs in the same cycle (the full check uses the pre-pop count).

Head outputs:
- origem/destino = mem[rd_ptr], combinational from registers.
- Stable for the whole time novaEntrada=1.

FSM (registered state; novaEntrada = state==APRESENTA):
- OCIOSO: if !vazio & !ocupado, go to APRESENTA; else stay.
- APRESENTA: if aceito, pop and go to INTERVALO; else stay. ocupado is ignored here.
- INTERVALO: unconditionally go to OCIOSO. This guarantees novaEntrada is low for at least 2 cycles between consecutive requests, so the downstream edge detector sees a fresh rising edge.

Latency:
- Press at edge E1 into an empty FIFO with ocupado=0 gives novaEntrada=1 after E2 (1-cycle latency from the write).
- aceito at Ek gives novaEntrada=0 after Ek.
- The next queued request is presented after Ek+2 at the earliest.

Wrap-around:
- Pointers are log2(DEPTH) bits and wrap naturally.
- cheio/vazio are derived from count, never from pointer equality.

Test Plan:
1. Reset, then press with origem_in=2, destino_in=7 -> vazio 0 and num_pedidos=1 one cycle after the press; novaEntrada=1 the next cycle with origem=2, destino=7; aceito pulse -> novaEntrada=0, vazio=1.
2. Press with origem_in=5, destino_in=5; then separately a press with origem_in=3, destino_in=15 while ANDAR_MAX=12 -> erro_pedido one-cycle pulse each time, num_pedidos stays 0, novaEntrada stays 0.
3. Push 4 valid pairs (1→4, 6→2, 0→9, 8→3) with ocupado=1, then a 5th press -> cheio=1, num_pedidos=4, erro_pedido pulse for the 5th, novaEntrada=0. Release ocupado and pop 4 times -> pairs emerge in push order, with novaEntrada low ≥2 cycles between each.
4. FIFO full, then a press coincident with aceito -> pop happens, push rejected, erro_pedido=1, num_pedidos=3. With count=2, a press plus aceito in the same cycle -> num_pedidos stays 2 and the new pair ends up at the tail.
5. Hold registra high across reset deassertion -> no write. Reset asserted while in APRESENTA with 3 queued -> next cycle novaEntrada=0, vazio=1, num_pedidos=0, origem=destino=0.
6. Push/pop 10 pairs continuously with DEPTH=4 -> pointers wrap; every pair emerges in order with no loss or duplication; aceito pulses while in OCIOSO or INTERVALO do not change num_pedidos.
